// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, applies branch/jump redirects and stalls,
// and registers the fetched word into IF/ID until the halt word is seen.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic [31:0] Read_Address,
   input  logic [31:0] Instruction,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PC_Plus1,
   output logic        IFID_Valid,
   output logic        Halted,
   output logic [31:0] Fetch_Count
);

   typedef enum logic {
      RUN,
      HALT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] pcp1_q, pcp1_d;
   logic        valid_q, valid_d;
   logic [31:0] cnt_q, cnt_d;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_plus1;

   assign redirect    = Branch_Taken | Jump;
   assign redirect_pc = Branch_Taken ? Branch_Target : Jump_Target;
   assign pc_plus1    = pc_q + 32'd1;

   // Redirect is checked first in both states; HALT ignores Stall entirely.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      pcp1_d  = pcp1_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;

      if (redirect) begin
         pc_d    = redirect_pc;
         ins_d   = '0;
         pcp1_d  = '0;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (state_q == HALT) begin
         ins_d   = '0;
         pcp1_d  = '0;
         valid_d = 1'b0;
      end else if (Stall) begin
         state_d = state_q;
      end else if (Instruction == HALT_WORD) begin
         ins_d   = '0;
         pcp1_d  = '0;
         valid_d = 1'b0;
         state_d = HALT;
      end else begin
         pc_d    = pc_plus1;
         ins_d   = Instruction;
         pcp1_d  = pc_plus1;
         valid_d = 1'b1;
         cnt_d   = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ins_q   <= '0;
         pcp1_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         pcp1_q  <= pcp1_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Read_Address     = pc_q;
   assign IFID_Instruction = ins_q;
   assign IFID_PC_Plus1    = pcp1_q;
   assign IFID_Valid       = valid_q;
   assign Halted           = (state_q == HALT);
   assign Fetch_Count      = cnt_q;

endmodule
